ram_master: RTL and testbench

//   Initiator side of the 256x16 synchronous RAM interface: owns write/addr/data_in and consumes data_out.

---
 rtl/ram_master.sv | 88 ++++++++
 tb/tb_ram_master.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ram_master.sv
// ram_master: sequences user requests and a full-memory clear onto a 256x16 synchronous RAM
module ram_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              wr_done,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, CLEAR} state_t;
  state_t              state_q;
  logic                rsp_valid_q, wr_done_q, clear_busy_q, ram_write_q;
  logic [DATA_W-1:0]   rsp_rdata_q, ram_data_in_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  // a pending clear_start wins over a request, so ready drops while it is asserted
  assign req_ready   = (state_q == IDLE) && !clear_start && !reset;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign wr_done     = wr_done_q;
  assign clear_busy  = clear_busy_q;
  assign ram_write   = ram_write_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data_in = ram_data_in_q;
  // control FSM: every RAM-side and response output is registered here
  always_ff @(posedge sysclk or posedge reset)
    if (reset) begin
      state_q       <= IDLE;
      rsp_valid_q   <= 1'b0;
      wr_done_q     <= 1'b0;
      clear_busy_q  <= 1'b0;
      ram_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      ram_data_in_q <= '0;
      ram_addr_q    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      wr_done_q   <= 1'b0;
      case (state_q)
        IDLE:
          if (clear_start) begin
            ram_addr_q    <= '0;
            ram_data_in_q <= '0;
            ram_write_q   <= 1'b1;
            clear_busy_q  <= 1'b1;
            state_q       <= CLEAR;
          end else if (req_valid) begin
            ram_addr_q    <= req_addr;
            ram_data_in_q <= req_wdata;
            ram_write_q   <= req_write;
            state_q       <= ISSUE;
          end
        ISSUE: begin
          ram_write_q <= 1'b0;
          wr_done_q   <= ram_write_q;
          state_q     <= ram_write_q ? IDLE : CAPTURE;
        end
        CAPTURE: begin
          rsp_rdata_q <= ram_data_out;
          rsp_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        CLEAR:
          if (ram_addr_q == ADDR_W'(DEPTH - 1)) begin
            ram_write_q  <= 1'b0;
            clear_busy_q <= 1'b0;
            ram_addr_q   <= '0;
            state_q      <= IDLE;
          end else begin
            ram_addr_q <= ram_addr_q + 1'b1;
          end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: table-driven and scoreboarded checks of ram_master against a behavioural RAM
module tb_ram_master;
  logic        sysclk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, clear_start = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready, rsp_valid, wr_done, clear_busy, ram_write;
  logic [15:0] rsp_rdata, ram_data_in, ram_data_out;
  logic [7:0]  ram_addr;
  typedef struct {logic w; logic [15:0] d; int c;} exp_t;
  typedef struct {logic w; logic [7:0] a; logic [15:0] d; logic [15:0] e;} vec_t;
  exp_t        q[$];
  vec_t        tv[6];
  int          acc[6];
  int          total = 0, bad = 0, cyc = 0, last_acc = 0;
  logic        prev_rsp = 1'b0, prev_wd = 1'b0;
  logic [15:0] mem [256];
  ram_master dut (
    .sysclk(sysclk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wr_done(wr_done),
    .clear_start(clear_start), .clear_busy(clear_busy), .ram_write(ram_write),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) begin
    cyc <= cyc + 1;
    if (ram_write) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  always @(negedge sysclk) begin
    if (reset) begin
      q.delete();
    end else begin
      if (rsp_valid && wr_done) chk("rsp_and_wr_done_together", 1, 0);
      if ((rsp_valid && prev_rsp) || (wr_done && prev_wd)) chk("pulse_width", 1, 0);
      if (rsp_valid || wr_done) begin
        if (q.size() == 0) chk("unexpected_response", {rsp_valid, wr_done}, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("response_kind", {rsp_valid, wr_done}, e.w ? 2'b01 : 2'b10);
          if (!e.w) chk("rsp_rdata", rsp_rdata, e.d);
          chk(e.w ? "write_latency" : "read_latency", cyc - e.c, e.w ? 2 : 3);
        end
      end
    end
    prev_rsp = rsp_valid;
    prev_wd  = wr_done;
  end
  task automatic req(input logic w, input logic [7:0] a, input logic [15:0] d, input logic [15:0] e);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    do begin @(negedge sysclk); n++; end while (!req_ready && n < 400);
    if (!req_ready) chk("accept_timeout", 0, 1);
    else begin
      q.push_back('{w, e, cyc});
      last_acc = cyc;
    end
    @(posedge sysclk); #1;
    req_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 20) begin @(negedge sysclk); n++; end
    if (q.size() != 0) begin
      chk("response_timeout", q.size(), 0);
      q.delete();
    end
    repeat (3) @(negedge sysclk);
    @(posedge sysclk); #1;
  endtask
  task automatic all_zero(input string nm);
    chk(nm, {req_ready, rsp_valid, wr_done, clear_busy, ram_write, rsp_rdata, ram_addr, ram_data_in}, 0);
  endtask
  initial begin
    int n, busy_n, wr_n, seq_bad;
    logic seen;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    tv[0] = '{1'b1, 8'h12, 16'hBEEF, 16'h0000};
    tv[1] = '{1'b0, 8'h12, 16'h0000, 16'hBEEF};
    tv[2] = '{1'b1, 8'h00, 16'h0001, 16'h0000};
    tv[3] = '{1'b1, 8'hFF, 16'hFFFF, 16'h0000};
    tv[4] = '{1'b0, 8'h00, 16'h0000, 16'h0001};
    tv[5] = '{1'b0, 8'hFF, 16'h0000, 16'hFFFF};
    #12 all_zero("reset_outputs");
    @(posedge sysclk); #1 reset = 1'b0;
    #1 chk("ready_after_reset", req_ready, 1);
    @(posedge sysclk); #1;
    for (int i = 0; i < 6; i++) begin
      req(tv[i].w, tv[i].a, tv[i].d, tv[i].e);
      acc[i] = last_acc;
    end
    wait_idle();
    for (int i = 0; i < 5; i++) chk("accept_spacing", acc[i+1] - acc[i], tv[i].w ? 2 : 3);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h12;
    @(negedge sysclk);
    @(posedge sysclk); #1 req_valid = 1'b0;
    #2 reset = 1'b1;
    #1 all_zero("async_reset_mid_read");
    @(posedge sysclk); #1 reset = 1'b0;
    #1 chk("ready_after_mid_reset", req_ready, 1);
    wait_idle();
    for (int i = 0; i < 256; i++) req(1'b1, 8'(i), 16'(i) ^ 16'hA5A5, 16'h0);
    req(1'b0, 8'h80, 16'h0, 16'hA525);
    req(1'b0, 8'hFF, 16'h0, 16'hA55A);
    wait_idle();
    clear_start = 1'b1;
    @(posedge sysclk); #1 clear_start = 1'b0;
    busy_n = 0; wr_n = 0; seq_bad = 0; n = 0;
    do begin
      @(negedge sysclk); n++;
      if (clear_busy) busy_n++;
      if (ram_write) begin
        if (ram_data_in != 16'h0 || ram_addr != 8'(wr_n)) seq_bad++;
        wr_n++;
      end
      if (n == 100) clear_start = 1'b1;
      if (n == 101) clear_start = 1'b0;
    end while (clear_busy && n < 400);
    chk("clear_busy_edges", busy_n + 1, 257);
    chk("clear_write_count", wr_n, 256);
    chk("clear_write_sequence", seq_bad, 0);
    @(posedge sysclk); #1;
    req(1'b0, 8'h00, 16'h0, 16'h0);
    req(1'b0, 8'h80, 16'h0, 16'h0);
    req(1'b0, 8'hFF, 16'h0, 16'h0);
    req(1'b1, 8'h10, 16'h1234, 16'h0);
    wait_idle();
    clear_start = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
    @(negedge sysclk) chk("ready_with_clear_start", req_ready, 0);
    @(posedge sysclk); #1 clear_start = 1'b0;
    n = 0; seen = 1'b0;
    do begin @(negedge sysclk); n++; if (clear_busy) seen = 1'b1; end while (!req_ready && n < 400);
    chk("clear_before_read", {seen, clear_busy, req_ready}, 3'b101);
    if (req_ready) q.push_back('{1'b0, 16'h0, cyc});
    @(posedge sysclk); #1 req_valid = 1'b0;
    wait_idle();
    req(1'b1, 8'h3F, 16'h1111, 16'h0);
    req(1'b1, 8'h40, 16'h3333, 16'h0);
    req(1'b1, 8'h41, 16'h2222, 16'h0);
    wait_idle();
    clear_start = 1'b1;
    @(posedge sysclk); #1 clear_start = 1'b0;
    n = 0;
    do begin @(negedge sysclk); n++; end while (ram_addr != 8'h40 && n < 400);
    chk("clear_reached_0x40", ram_addr, 8'h40);
    reset = 1'b1;
    #1 chk("reset_mid_clear", {clear_busy, ram_write, ram_addr}, 0);
    @(posedge sysclk); #1 reset = 1'b0;
    req(1'b0, 8'h3F, 16'h0, 16'h0000);
    req(1'b0, 8'h40, 16'h0, 16'h3333);
    req(1'b0, 8'h41, 16'h0, 16'h2222);
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
